// File: rtl/damage_accumulator_if.sv
// rtl/damage_accumulator_if.sv - request/snapshot inputs and result outputs of damage_accumulator
interface damage_accumulator_if #(
   parameter int N_BULLETS = 8,
   parameter int DMG_W     = 8
);
   localparam int IDX_W = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1;

   logic                   start;
   logic [N_BULLETS-1:0]   collide;
   logic [3*N_BULLETS-1:0] color;
   logic                   is_move;
   logic [DMG_W-1:0]       damage;
   logic                   complete;
   logic                   busy;
   logic [IDX_W-1:0]       index;

   modport master (
      output start, collide, color, is_move,
      input  damage, complete, busy, index
   );

   modport slave (
      input  start, collide, color, is_move,
      output damage, complete, busy, index
   );
endinterface

// File: rtl/damage_accumulator.sv
// rtl/damage_accumulator.sv - snapshot-and-scan bullet damage accumulator with saturating total
// Optional i-frame suppression is compiled in with INVINCIBILITY_EN.
module damage_accumulator #(
   parameter int N_BULLETS = 8,
   parameter int DMG_W     = 8,
   parameter int DMG_WHITE = 4,
   parameter int DMG_COLOR = 8
`ifdef INVINCIBILITY_EN
   ,parameter int IFRAMES  = 60
`endif
) (
   input  logic                clk,
   input  logic                reset,
   damage_accumulator_if.slave bus
);
   localparam int               IDX_W     = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_BULLETS - 1);
   localparam logic [DMG_W:0]   ADD_WHITE = (DMG_W+1)'(DMG_WHITE);
   localparam logic [DMG_W:0]   ADD_COLOR = (DMG_W+1)'(DMG_COLOR);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;

   logic [N_BULLETS-1:0]   r_collide;
   logic [3*N_BULLETS-1:0] r_color;
   logic                   r_is_move;
   logic [IDX_W-1:0]       r_index;
   logic [DMG_W-1:0]       r_acc;
   logic [DMG_W-1:0]       r_damage;
   logic                   r_complete;
   logic                   r_busy;

   logic                   w_accept;
   logic                   w_last;
   logic [2:0]             w_ch_color;
   logic                   w_ch_collide;
   logic [DMG_W:0]         w_add;
   logic [DMG_W:0]         w_sum;
   logic [DMG_W-1:0]       w_acc_next;

`ifdef INVINCIBILITY_EN
   localparam int          IF_W = (IFRAMES > 0) ? $clog2(IFRAMES + 1) : 1;
   logic [IF_W-1:0]        r_iframes;
   logic                   r_shield;
`endif

   assign w_accept = (r_state == S_IDLE) && bus.start;
   assign w_last   = (r_index == LAST_IDX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_next = S_SCAN;
         S_SCAN:  if (w_last)    w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Hit rule is applied to the snapshot only; live inputs are ignored once a pass starts.
   always_comb begin
      w_ch_color   = r_color[int'(r_index)*3 +: 3];
      w_ch_collide = r_collide[r_index];
      w_add        = '0;
      if (w_ch_collide) begin
         case (w_ch_color)
            3'b001:  w_add = ADD_WHITE;
            3'b010:  w_add = r_is_move ? ADD_COLOR : '0;
            3'b100:  w_add = r_is_move ? '0 : ADD_COLOR;
            default: w_add = '0;
         endcase
      end
      w_sum      = {1'b0, r_acc} + w_add;
      w_acc_next = w_sum[DMG_W] ? '1 : w_sum[DMG_W-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_collide  <= '0;
         r_color    <= '0;
         r_is_move  <= 1'b0;
         r_index    <= '0;
         r_acc      <= '0;
         r_damage   <= '0;
         r_complete <= 1'b0;
         r_busy     <= 1'b0;
`ifdef INVINCIBILITY_EN
         r_iframes  <= '0;
         r_shield   <= 1'b0;
`endif
      end else begin
         r_complete <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_collide <= bus.collide;
                  r_color   <= bus.color;
                  r_is_move <= bus.is_move;
                  r_acc     <= '0;
                  r_index   <= '0;
                  r_busy    <= 1'b1;
`ifdef INVINCIBILITY_EN
                  // Shield is decided by the count seen at accept, before it ticks down.
                  r_shield  <= (r_iframes != '0);
                  if (r_iframes != '0) r_iframes <= r_iframes - 1'b1;
`endif
               end
            end
            S_SCAN: begin
               r_acc   <= w_acc_next;
               r_index <= w_last ? '0 : r_index + 1'b1;
            end
            S_DONE: begin
               r_complete <= 1'b1;
               r_busy     <= 1'b0;
`ifdef INVINCIBILITY_EN
               r_damage   <= r_shield ? '0 : r_acc;
               if (!r_shield && (r_acc != '0)) r_iframes <= IF_W'(IFRAMES);
`else
               r_damage   <= r_acc;
`endif
            end
            default: r_busy <= 1'b0;
         endcase
      end
   end

   assign bus.damage   = r_damage;
   assign bus.complete = r_complete;
   assign bus.busy     = r_busy;
   assign bus.index    = r_index;
endmodule
